regfile_onehot_wr: RTL
======================

Name: regfile_onehot_wr

Overview:
- 32-entry integer register file for the RISC-V pipeline.
- Sits directly downstream of the write-enable decoder and consumes its one-hot 32-bit write-enable vector plus the writeback data from the WB stage.
- Provides two asynchronous read ports to the ID stage, with optional write-to-read bypass so that a same-cycle writeback is visible to decode.
- Also flags illegal (multi-hot) write-enable vectors.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
BYPASS, 1, 1 = read ports return WriteData when the addressed register is being written this cycle; 0 = read returns the stored value only

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
WriteEn  input  32  one-hot write enable from the decoder; bit i selects register i
WriteData  input  DATA_WIDTH  writeback data from the WB stage
ReadReg1  input  5  read port 1 address (rs1)
ReadReg2  input  5  read port 2 address (rs2)
ReadData1  output  DATA_WIDTH  read port 1 data, combinational
ReadData2  output  DATA_WIDTH  read port 2 data, combinational
MultiWeErr  output  1  sticky flag, set when more than one WriteEn bit is high at a clock edge
WriteCount  output  16  number of accepted writes since reset, saturating

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n low, at any time including mid-write):
  - Registers 1..31 clear to 0 immediately.
  - MultiWeErr clears to 0.
  - WriteCount clears to 0.
  - A write coinciding with the reset-release edge is not performed.
- Register 0:
  - Reads always return 0.
  - WriteEn[0] is ignored; no storage is written.
- Write: on the rising edge of clk with rst_n high, every register i (1..31) whose WriteEn[i]=1 loads WriteData.
  - Write latency is 1 cycle: a non-bypassed read returns the new value from the cycle after the edge.
- Accepted write:
  - Defined as an edge where exactly one of WriteEn[31:1] is high and no other WriteEn bit is high.
  - WriteCount increments by 1 on each accepted write and saturates at 16'hFFFF (no wrap).
- Multi-hot vector (popcount(WriteEn) >= 2, counting bit 0):
  - All selected registers 1..31 are still written with WriteData; no gating.
  - MultiWeErr goes to 1 on that edge and stays 1 until reset.
  - WriteCount does not increment.
- Zero vector, or only WriteEn[0] set: no state change; no error; no count.
- Reads:
  - Purely combinational in the addresses and state.
  - With BYPASS=1: if ReadRegN != 0 and WriteEn[ReadRegN]=1 in the current cycle, ReadDataN = WriteData; otherwise ReadDataN = stored value.
  - With BYPASS=0: ReadDataN always equals the stored value.
  - Both ports may address the same register with identical results.
- All outputs are defined (no X) after reset, for any input combination.

Test Plan:
- Reset: drive rst_n=0 mid-simulation after writing 0xDEADBEEF to x5 -> ReadData1 with ReadReg1=5 reads 0 immediately (before the next edge); MultiWeErr=0; WriteCount=0.
- Basic write/read: WriteEn=32'h0000_0400 (x10), WriteData=0x1234_5678, one edge, then WriteEn=0 -> ReadReg1=10 gives 0x12345678; ReadReg2=10 gives the same; WriteCount=1.
- x0 immunity: WriteEn=32'h0000_0001, WriteData=0xFFFF_FFFF -> ReadReg1=0 gives 0; WriteCount stays 0; MultiWeErr=0.
- Bypass, BYPASS=1: x7 holds 0xAAAA_0000; in the same cycle WriteEn=32'h80, WriteData=0x5555_1111, ReadReg1=7 -> ReadData1=0x55551111 before the edge. With BYPASS=0 the same stimulus gives 0xAAAA0000 before the edge and 0x55551111 after it.
- Multi-hot: WriteEn=32'h0000_0006, WriteData=0x0000_00C3 -> x1 and x2 both read 0xC3; MultiWeErr=1 and remains 1 after 10 idle cycles; WriteCount unchanged.
- Saturation and back-to-back writes: 65,540 consecutive single-hot writes cycling x1..x31 -> WriteCount=16'hFFFF; each register holds the last value written to it.

Source files
------------

// File: rtl/regfile_onehot_wr.sv
// 32-entry integer register file driven by a one-hot write-enable vector.
// Two combinational read ports with optional same-cycle write bypass, a sticky multi-hot error flag and a saturating write counter.
module regfile_onehot_wr #(
   parameter int DATA_WIDTH = 32,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           WriteEn,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [4:0]            ReadReg1,
   input  logic [4:0]            ReadReg2,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   output logic                  MultiWeErr,
   output logic [15:0]           WriteCount
);

   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   logic [DATA_WIDTH-1:0] regs [32];
   logic                  any_hot;
   logic                  multi_hot;
   logic                  accepted;
   logic [4:0]            raddr [2];
   logic [DATA_WIDTH-1:0] rdata [2];

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   always_comb begin
      any_hot   = |WriteEn;
      multi_hot = |(WriteEn & (WriteEn - 32'd1));
      accepted  = any_hot && !multi_hot && !WriteEn[0];
   end

   // NOTE: the register array is reset on purpose: the reset contract requires every
   // architectural register to read 0 right after rst_n asserts, so it cannot map to a RAM macro.
   // Entry 0 is kept in the loop so it stays driven, but it is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            // NOTE: sequential state always uses non-blocking assignment so every flop
            // samples pre-edge values regardless of block evaluation order.
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (WriteEn[i]) begin
               regs[i] <= WriteData;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MultiWeErr <= 1'b0;
      end else if (multi_hot) begin
         MultiWeErr <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WriteCount <= '0;
      end else if (accepted && (WriteCount != COUNT_MAX)) begin
         WriteCount <= WriteCount + 16'd1;
      end
   end

   assign raddr[0] = ReadReg1;
   assign raddr[1] = ReadReg2;

   // Both ports share one description; x0 is hardwired to zero ahead of any bypass.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         // NOTE: default first so no path through this block leaves rdata unassigned (no latch).
         rdata[p] = '0;
         if (raddr[p] != 5'd0) begin
            rdata[p] = regs[raddr[p]];
            if (BYPASS && WriteEn[raddr[p]]) begin
               rdata[p] = WriteData;
            end
         end
      end
   end

   assign ReadData1 = rdata[0];
   assign ReadData2 = rdata[1];

endmodule
